// File: rtl/sevenseg_time_display_if.sv
// Display-side bundle: the timer drives the BCD time and the control flags,
// and the display driver returns the registered pin levels.
interface sevenseg_time_display_if;
  logic [15:0] big_bin;
  logic        alarm;
  logic        colon;
  logic        blank_lead;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output big_bin, alarm, colon, blank_lead,
    input  an, seg, dp
  );

  modport slave (
    input  big_bin, alarm, colon, blank_lead,
    output an, seg, dp
  );
endinterface

// File: rtl/sevenseg_time_display.sv
// Time-multiplexes a 4-digit BCD mm:ss value onto a common-anode 7-segment
// display, with colon point, leading-zero blanking and alarm blinking.
module sevenseg_time_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  sevenseg_time_display_if.slave  bus
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [3:0] POL_AN  = {4{ACTIVE_LOW}};
  localparam logic [6:0] POL_SEG = {7{ACTIVE_LOW}};

  typedef enum logic {
    VISIBLE = 1'b0,
    DARK    = 1'b1
  } phase_t;

  phase_t           r_phase;
  phase_t           w_phase_next;
  logic [REF_W-1:0] r_ref_cnt;
  logic [1:0]       r_idx;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             w_ref_wrap;
  logic             w_blink_wrap;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_pat;
  logic             w_lit;
  logic [3:0]       w_an_on;
  logic [6:0]       w_seg_on;
  logic             w_dp_on;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  assign w_ref_wrap   = (r_ref_cnt == REF_LAST);
  assign w_blink_wrap = (r_blink_cnt == BLK_LAST);

  // Digit slot timer: advance to the next digit every REFRESH_DIV clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
    end else if (w_ref_wrap) begin
      r_ref_cnt <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // Blink half-period timer; held at zero while the alarm is idle so a new
  // alarm always begins with a full visible half-period.
  always_ff @(posedge clock) begin
    if (reset || !bus.alarm) begin
      r_blink_cnt <= '0;
    end else if (w_blink_wrap) begin
      r_blink_cnt <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLK_W'(1);
    end
  end

  // Blink phase state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase <= VISIBLE;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Blink phase next-state: toggle at each terminal count, snap visible when alarm drops.
  always_comb begin
    w_phase_next = r_phase;
    if (!bus.alarm) begin
      w_phase_next = VISIBLE;
    end else if (w_blink_wrap) begin
      w_phase_next = (r_phase == VISIBLE) ? DARK : VISIBLE;
    end
  end

  // Select the nibble for the current slot and decode it (active-high pattern).
  always_comb begin
    w_nibble = '0;
    case (r_idx)
      2'd0: w_nibble = bus.big_bin[3:0];
      2'd1: w_nibble = bus.big_bin[7:4];
      2'd2: w_nibble = bus.big_bin[11:8];
      2'd3: w_nibble = bus.big_bin[15:12];
      default: w_nibble = '0;
    endcase
    w_seg_pat = 7'h40;
    case (w_nibble)
      4'd0: w_seg_pat = 7'h3F;
      4'd1: w_seg_pat = 7'h06;
      4'd2: w_seg_pat = 7'h5B;
      4'd3: w_seg_pat = 7'h4F;
      4'd4: w_seg_pat = 7'h66;
      4'd5: w_seg_pat = 7'h6D;
      4'd6: w_seg_pat = 7'h7D;
      4'd7: w_seg_pat = 7'h07;
      4'd8: w_seg_pat = 7'h7F;
      4'd9: w_seg_pat = 7'h6F;
      default: w_seg_pat = 7'h40;
    endcase
  end

  // Decide whether this slot is lit and form the active-high pin values.
  always_comb begin
    w_lit    = (r_phase == VISIBLE) &&
               !(bus.blank_lead && (r_idx == 2'd3) && (bus.big_bin[15:12] == 4'd0));
    w_an_on  = '0;
    w_seg_on = '0;
    w_dp_on  = 1'b0;
    if (w_lit) begin
      w_an_on  = 4'b0001 << r_idx;
      w_seg_on = w_seg_pat;
      w_dp_on  = (r_idx == 2'd2) && bus.colon;
    end
  end

  // Registered pins with polarity applied; reset drives everything inactive.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_an  <= POL_AN;
      r_seg <= POL_SEG;
      r_dp  <= ACTIVE_LOW;
    end else begin
      r_an  <= w_an_on ^ POL_AN;
      r_seg <= w_seg_on ^ POL_SEG;
      r_dp  <= w_dp_on ^ ACTIVE_LOW;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_time_display.sv
// Directed bench for sevenseg_time_display with short refresh/blink periods.
module tb_sevenseg_time_display;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  sevenseg_time_display_if u_if ();

  sevenseg_time_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16),
    .ACTIVE_LOW  (1'b1)
  ) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge then release; the next tick shows slot 0.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    u_if.big_bin    = 16'h0000;
    u_if.alarm      = 1'b0;
    u_if.colon      = 1'b0;
    u_if.blank_lead = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (u_if.an !== 4'hF) begin
      n_miss++;
      $display("FAIL reset_an got=%h exp=%h", u_if.an, 4'hF);
    end
    n_vec++;
    if (u_if.seg !== 7'h7F) begin
      n_miss++;
      $display("FAIL reset_seg got=%h exp=%h", u_if.seg, 7'h7F);
    end
    n_vec++;
    if (u_if.dp !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_dp got=%b exp=%b", u_if.dp, 1'b1);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (u_if.an !== 4'b1110 || u_if.seg !== 7'h40) begin
      n_miss++;
      $display("FAIL reset_first_lit got an=%b seg=%h exp an=1110 seg=40", u_if.an, u_if.seg);
    end
  endtask

  task automatic test_scan_1234();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg[4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    u_if.big_bin    = 16'h1234;
    u_if.colon      = 1'b0;
    u_if.blank_lead = 1'b0;
    u_if.alarm      = 1'b0;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      int s;
      tick();
      s = ((k - 1) / 4) % 4;
      n_vec++;
      if (u_if.an !== exp_an[s] || u_if.seg !== exp_seg[s] || u_if.dp !== 1'b1) begin
        n_miss++;
        $display("FAIL scan_1234 k=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=1",
                 k, u_if.an, u_if.seg, u_if.dp, exp_an[s], exp_seg[s]);
      end
    end
  endtask

  task automatic test_blank_colon();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg[4];
    logic       exp_dp [4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    exp_seg = '{7'h10, 7'h40, 7'h12, 7'h7F};
    exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    u_if.big_bin    = 16'h0509;
    u_if.colon      = 1'b1;
    u_if.blank_lead = 1'b1;
    u_if.alarm      = 1'b0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      int s;
      tick();
      s = ((k - 1) / 4) % 4;
      n_vec++;
      if (u_if.an !== exp_an[s] || u_if.seg !== exp_seg[s] || u_if.dp !== exp_dp[s]) begin
        n_miss++;
        $display("FAIL blank_colon k=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                 k, u_if.an, u_if.seg, u_if.dp, exp_an[s], exp_seg[s], exp_dp[s]);
      end
    end
    // Same value without blanking: the leading zero is shown.
    u_if.blank_lead = 1'b0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k >= 13) begin
        n_vec++;
        if (u_if.an !== 4'b0111 || u_if.seg !== 7'h40 || u_if.dp !== 1'b1) begin
          n_miss++;
          $display("FAIL noblank_lead k=%0d got an=%b seg=%h dp=%b exp an=0111 seg=40 dp=1",
                   k, u_if.an, u_if.seg, u_if.dp);
        end
      end
    end
  endtask

  task automatic test_dash();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg[4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'h40, 7'h40, 7'h40, 7'h3F};
    u_if.big_bin    = 16'hA000;
    u_if.colon      = 1'b0;
    u_if.blank_lead = 1'b1;
    u_if.alarm      = 1'b0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      int s;
      tick();
      s = ((k - 1) / 4) % 4;
      n_vec++;
      if (u_if.an !== exp_an[s] || u_if.seg !== exp_seg[s]) begin
        n_miss++;
        $display("FAIL dash k=%0d got an=%b seg=%h exp an=%b seg=%h",
                 k, u_if.an, u_if.seg, exp_an[s], exp_seg[s]);
      end
    end
  endtask

  task automatic test_alarm_blink();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg[4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    u_if.big_bin    = 16'h1234;
    u_if.colon      = 1'b0;
    u_if.blank_lead = 1'b0;
    u_if.alarm      = 1'b1;
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      int s;
      bit visible;
      tick();
      s = ((k - 1) / 4) % 4;
      // 1..16 visible, 17..32 dark, 33..48 visible, 49.. dark; alarm dropped after 52.
      visible = (k <= 16) || (k >= 33 && k <= 48) || (k >= 54);
      n_vec++;
      if (visible) begin
        if (u_if.an !== exp_an[s] || u_if.seg !== exp_seg[s]) begin
          n_miss++;
          $display("FAIL blink_visible k=%0d got an=%b seg=%h exp an=%b seg=%h",
                   k, u_if.an, u_if.seg, exp_an[s], exp_seg[s]);
        end
      end else begin
        if (u_if.an !== 4'hF || u_if.seg !== 7'h7F || u_if.dp !== 1'b1) begin
          n_miss++;
          $display("FAIL blink_dark k=%0d got an=%b seg=%h dp=%b exp an=1111 seg=7f dp=1",
                   k, u_if.an, u_if.seg, u_if.dp);
        end
      end
      if (k == 52) u_if.alarm = 1'b0;
    end
  endtask

  task automatic test_reset_mid_blink();
    u_if.big_bin    = 16'h1234;
    u_if.colon      = 1'b1;
    u_if.blank_lead = 1'b0;
    u_if.alarm      = 1'b1;
    do_reset();
    for (int k = 1; k <= 10; k++) tick();
    n_vec++;
    if (u_if.an !== 4'b1011 || u_if.dp !== 1'b0) begin
      n_miss++;
      $display("FAIL midblink_pre got an=%b dp=%b exp an=1011 dp=0", u_if.an, u_if.dp);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (u_if.an !== 4'hF || u_if.seg !== 7'h7F || u_if.dp !== 1'b1) begin
      n_miss++;
      $display("FAIL midblink_reset got an=%b seg=%h dp=%b exp an=1111 seg=7f dp=1",
               u_if.an, u_if.seg, u_if.dp);
    end
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) begin
        n_vec++;
        if (u_if.an !== 4'b1110 || u_if.seg !== 7'h19) begin
          n_miss++;
          $display("FAIL midblink_restart got an=%b seg=%h exp an=1110 seg=19", u_if.an, u_if.seg);
        end
      end
      if (k == 16) begin
        n_vec++;
        if (u_if.an !== 4'b0111) begin
          n_miss++;
          $display("FAIL midblink_lastvis got an=%b exp an=0111", u_if.an);
        end
      end
      if (k == 17) begin
        n_vec++;
        if (u_if.an !== 4'hF) begin
          n_miss++;
          $display("FAIL midblink_dark got an=%b exp an=1111", u_if.an);
        end
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    test_reset();
    test_scan_1234();
    test_blank_colon();
    test_dash();
    test_alarm_blink();
    test_reset_mid_blink();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
